// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared source indices, load codes and FSM states for the writeback stage
package wb_pkg;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_PC4  = 2;
    localparam int WB_CSR  = 3;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_funct3_t;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } wb_state_t;

endpackage

// File: rtl/wb_select_unit_if.sv
// rtl/wb_select_unit_if.sv - MEM/WB handshake and register-file write port bundle
interface wb_select_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int RA_W    = 5,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        wb_sel;
    logic [NUM_SRC*XLEN-1:0] src_data;
    logic [2:0]              ld_funct3;
    logic [1:0]              ld_addr_lo;
    logic [RA_W-1:0]         rd;
    logic                    reg_wr;
    logic                    mem_rvalid;
    logic                    rf_we;
    logic [RA_W-1:0]         rf_waddr;
    logic [XLEN-1:0]         rf_wdata;
    logic                    ld_misalign;

    modport master (
        output in_valid, wb_sel, src_data, ld_funct3, ld_addr_lo, rd, reg_wr, mem_rvalid,
        input  in_ready, rf_we, rf_waddr, rf_wdata, ld_misalign
    );

    modport slave (
        input  in_valid, wb_sel, src_data, ld_funct3, ld_addr_lo, rd, reg_wr, mem_rvalid,
        output in_ready, rf_we, rf_waddr, rf_wdata, ld_misalign
    );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load byte/half extraction, extension and misalignment detect
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ext_data,
    output logic            misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = data[{addr_lo, 3'b000} +: 8];
    assign half_v = data[{addr_lo[1], 4'b0000} +: 16];

    // Anything not a byte/half code behaves as a full word.
    always_comb begin
        ext_data = data;
        misalign = 1'b0;
        case (funct3)
            LD_LB:  ext_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            LD_LBU: ext_data = {{(XLEN-8){1'b0}}, byte_v};
            LD_LH: begin
                ext_data = {{(XLEN-16){half_v[15]}}, half_v};
                misalign = addr_lo[0];
            end
            LD_LHU: begin
                ext_data = {{(XLEN-16){1'b0}}, half_v};
                misalign = addr_lo[0];
            end
            default: begin
                ext_data = data;
                misalign = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/wb_select_unit.sv
// rtl/wb_select_unit.sv - registered writeback stage with source select and load-wait stall
module wb_select_unit
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 4,
    parameter int LOAD_SRC = WB_LOAD,
    parameter int RA_W     = 5,
    parameter int SEL_W    = $clog2(NUM_SRC)
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_select_unit_if.slave   bus
);

    localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_SRC);

    wb_state_t       state;
    logic [RA_W-1:0] cap_rd;
    logic [2:0]      cap_f3;
    logic [1:0]      cap_lo;
    logic            cap_wr;

    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] ext_data;
    logic [2:0]      al_f3;
    logic [1:0]      al_lo;
    logic            misalign;
    logic            is_load;

    assign bus.in_ready = (state == IDLE);
    assign is_load      = (bus.wb_sel == LOAD_SEL);
    assign load_data    = bus.src_data[LOAD_SRC*XLEN +: XLEN];

    // Out-of-range selects fall through to source 0.
    always_comb begin
        sel_data = bus.src_data[0 +: XLEN];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.wb_sel == SEL_W'(i)) sel_data = bus.src_data[i*XLEN +: XLEN];
        end
    end

    assign al_f3 = (state == WAIT_MEM) ? cap_f3 : bus.ld_funct3;
    assign al_lo = (state == WAIT_MEM) ? cap_lo : bus.ld_addr_lo;

    load_align #(.XLEN(XLEN)) u_align (
        .data     (load_data),
        .funct3   (al_f3),
        .addr_lo  (al_lo),
        .ext_data (ext_data),
        .misalign (misalign)
    );

    // Address/data registers only move on an actual write so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.rf_we       <= 1'b0;
            bus.rf_waddr    <= '0;
            bus.rf_wdata    <= '0;
            bus.ld_misalign <= 1'b0;
            cap_rd          <= '0;
            cap_f3          <= '0;
            cap_lo          <= '0;
            cap_wr          <= 1'b0;
        end else begin
            bus.rf_we       <= 1'b0;
            bus.ld_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (!is_load) begin
                            if (bus.reg_wr && bus.rd != '0) begin
                                bus.rf_we    <= 1'b1;
                                bus.rf_waddr <= bus.rd;
                                bus.rf_wdata <= sel_data;
                            end
                        end else if (bus.mem_rvalid) begin
                            bus.ld_misalign <= misalign;
                            if (bus.reg_wr && bus.rd != '0 && !misalign) begin
                                bus.rf_we    <= 1'b1;
                                bus.rf_waddr <= bus.rd;
                                bus.rf_wdata <= ext_data;
                            end
                        end else begin
                            cap_rd <= bus.rd;
                            cap_f3 <= bus.ld_funct3;
                            cap_lo <= bus.ld_addr_lo;
                            cap_wr <= bus.reg_wr;
                            state  <= WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid) begin
                        state           <= IDLE;
                        bus.ld_misalign <= misalign;
                        if (cap_wr && cap_rd != '0 && !misalign) begin
                            bus.rf_we    <= 1'b1;
                            bus.rf_waddr <= cap_rd;
                            bus.rf_wdata <= ext_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_select_unit.md
# wb_select_unit

Parametrised, registered writeback stage for the pipelined core. It replaces the purely combinational writeback multiplexer with a handshaked MEM/WB boundary that:
- selects one of `NUM_SRC` result sources;
- aligns and sign/zero-extends load data;
- stalls on late memory read responses;
- drives the register-file write port and the WB forwarding path from registered outputs.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NUM_SRC`, 4, number of writeback sources (0 ALU, 1 load, 2 PC+4, 3 CSR).
- `LOAD_SRC`, 1, source index that carries raw memory read data.
- `RA_W`, 5, register address width.
- `SEL_W`, `$clog2(NUM_SRC)`, select width (derived).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  MEM stage presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `wb_sel`  in  `SEL_W`  source select.
- `src_data`  in  `NUM_SRC*XLEN`  flattened sources; source i is bits [i*XLEN +: XLEN].
- `ld_funct3`  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- `ld_addr_lo`  in  2  byte offset of the load address.
- `rd`  in  `RA_W`  destination register.
- `reg_wr`  in  1  instruction writes rd.
- `mem_rvalid`  in  1  read data on source `LOAD_SRC` is valid.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  `RA_W`  write address.
- `rf_wdata`  out  `XLEN`  write data.
- `ld_misalign`  out  1  single-cycle pulse: misaligned load dropped.

## Operation
- Handshake: an instruction transfers on a cycle where `in_valid && in_ready`.
- State machine:
  - `IDLE`: `in_ready`=1.
  - Transfer with `wb_sel != LOAD_SRC`: registers the selected source, rd and `reg_wr`. Stays in `IDLE`.
  - Transfer of a load with `mem_rvalid`=1 in the same cycle: completes immediately. Stays in `IDLE`.
  - Transfer of a load with `mem_rvalid`=0: captures rd, funct3 and addr_lo, then moves to `WAIT_MEM`.
  - `WAIT_MEM`: `in_ready`=0. Upper-stage inputs other than `mem_rvalid` and source `LOAD_SRC` are ignored. On `mem_rvalid`=1, completes with the captured fields and returns to `IDLE`.
- Load alignment:
  - byte = data >> (8*addr_lo); half = data >> (16*addr_lo[1]).
  - lb/lh sign-extend to `XLEN`; lbu/lhu zero-extend; lw passes through.
- Misalignment: lh/lhu with addr_lo[0]=1, or lw with addr_lo≠0. The instruction completes with no write and `ld_misalign` pulses for one cycle.
- Undefined `ld_funct3` is treated as lw.
- Out-of-range `wb_sel` (≥ `NUM_SRC`) selects source 0.
- `rf_we` = `reg_wr` && rd≠0 && !misalign, registered at completion.
- `rf_we` is a one-cycle pulse per completed instruction. It is 0 in any cycle without a completion.
- `rf_waddr`/`rf_wdata` hold their last value when `rf_we`=0.
- `mem_rvalid` asserted in `IDLE` without a load transfer is ignored.

## Timing
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `ld_misalign`=0, state `IDLE`. `in_ready`=1 while `rst_n` is low.
- Non-load latency: outputs are valid the cycle after transfer.
- Load latency: outputs are valid the cycle after the edge where `mem_rvalid`=1. Minimum 1 cycle after transfer.
- `in_ready` is a combinational function of state only: `IDLE` gives 1, `WAIT_MEM` gives 0. It has no combinational path from `in_valid`.
- Throughput is 1 instruction/cycle when there are no load waits.
- Reset asserted in `WAIT_MEM` aborts the pending load: no write, state returns to `IDLE` immediately.
- Completion of a load in `WAIT_MEM` and acceptance of the next instruction never occur in the same cycle. The next transfer is possible one cycle later.

## Structure
- Package `wb_pkg`:
  - `localparam` source indices (`WB_ALU`, `WB_LOAD`, `WB_PC4`, `WB_CSR`);
  - `typedef enum` for load funct3 codes;
  - `typedef enum` `wb_state_t {IDLE, WAIT_MEM}`.
- Sub-module `load_align`: purely combinational (data, funct3, addr_lo) → (ext_data, misalign), parametrised by `XLEN`. It is instantiated once, fed by the source-`LOAD_SRC` slice and the mux of live/captured funct3/addr_lo.

## Test plan
- Reset, then ALU transfer with src0=0x0000_1234, rd=5, `reg_wr`=1 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x0000_1234. Following idle cycle: `rf_we`=0.
- lb, addr_lo=3, data=0x80FF_0011, `mem_rvalid`=1 on accept → `rf_wdata`=0xFFFF_FF80. Same case as lbu → 0x0000_0080.
- lh, addr_lo=2, `mem_rvalid` delayed 3 cycles, data=0x8001_0000 → `in_ready`=0 for 3 cycles, then `rf_wdata`=0xFFFF_8001 one cycle after `mem_rvalid`.
- lw with addr_lo=1, rd=7 → `ld_misalign` pulses 1 cycle, `rf_we`=0. Write to rd=0 via PC+4 source → `rf_we`=0.
- Back-to-back ALU, PC+4 (0x0000_0104), CSR (0xDEAD_BEEF) on rd 1,2,3 → three consecutive `rf_we` pulses with matching data, `in_ready` held at 1.
- Load waiting in `WAIT_MEM`, `rst_n` pulsed low mid-wait, `mem_rvalid` asserted after reset → no write, `in_ready`=1, outputs zero.
